// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: pipelined ID stage with register file, WB bypass, load-use stall and flush
module decode_stage_pipe #(
  parameter int BUS   = 32,
  parameter int NREGS = 16,
  parameter int IMMW  = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [31:0]                instruction,
  input  logic [BUS-1:0]             PCi,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       WE,
  input  logic [$clog2(NREGS)-1:0]   RDwb,
  input  logic [BUS-1:0]             WBd,
  input  logic                       flush,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [BUS-1:0]             OPA,
  output logic [BUS-1:0]             OPB,
  output logic [BUS-1:0]             STR_DATA,
  output logic [BUS-1:0]             RKo,
  output logic [BUS-1:0]             PCo,
  output logic [$clog2(NREGS)-1:0]   RDo,
  output logic [1:0]                 FUNTYPE,
  output logic [1:0]                 FUNCODE,
  output logic                       selWB,
  output logic                       selMEMRD,
  output logic                       selMEMWR,
  output logic                       selCACHEWR,
  output logic                       selCACHESH,
  output logic                       selBRANCH
);
  localparam int RW = $clog2(NREGS);
  typedef struct packed {
    logic [BUS-1:0] opa;
    logic [BUS-1:0] opb;
    logic [BUS-1:0] str;
    logic [BUS-1:0] rk;
    logic [BUS-1:0] pc;
    logic [RW-1:0]  rd;
    logic [1:0]     ft;
    logic [1:0]     fc;
    logic [5:0]     sel;
  } idex_t;
  logic [BUS-1:0] regs_q [NREGS];
  logic [1:0]     ft, fc;
  logic [RW-1:0]  rd, ra, rb;
  logic [IMMW-1:0] imm;
  logic           ii, mem, st_cand, adv, hazard;
  logic [BUS-1:0] sext, ra_v, rb_v, rd_v;
  idex_t          dec, idex_d, idex_q;
  logic           vld_d, vld_q;
  assign ft   = instruction[31:30];
  assign fc   = instruction[29:28];
  assign rd   = instruction[24 +: RW];
  assign ra   = instruction[20 +: RW];
  assign rb   = instruction[16 +: RW];
  assign imm  = instruction[IMMW:1];
  assign ii   = instruction[0];
  assign sext = {{(BUS-IMMW){imm[IMMW-1]}}, imm};
  assign mem  = ft == 2'b01;
  assign st_cand = mem & (fc == 2'b01 | fc == 2'b10);
  assign ra_v = ra == '0 ? '0 : (WE && RDwb == ra) ? WBd : regs_q[ra];
  assign rb_v = rb == '0 ? '0 : (WE && RDwb == rb) ? WBd : regs_q[rb];
  assign rd_v = rd == '0 ? '0 : (WE && RDwb == rd) ? WBd : regs_q[rd];
  assign adv    = !vld_q | out_ready;
  assign hazard = vld_q & idex_q.sel[4] & idex_q.rd != '0 &
                  (idex_q.rd == ra | (!ii & idex_q.rd == rb) | (st_cand & idex_q.rd == rd));
  assign in_ready = adv & !hazard & !flush;
  // decode the incoming word into the payload the ID/EX register would capture
  always_comb begin
    dec.opa = ra_v;
    dec.opb = ii ? sext : rb_v;
    dec.str = rd_v;
    dec.rk  = sext;
    dec.pc  = PCi;
    dec.rd  = rd;
    dec.ft  = ft;
    dec.fc  = fc;
    dec.sel = {ft == 2'b00 | (mem & fc == 2'b00), mem & fc == 2'b00, mem & fc == 2'b01,
               mem & fc == 2'b10, mem & fc == 2'b11, ft == 2'b10};
  end
  // ID/EX next state: flush kills, stall holds, hazard or empty input inserts a bubble
  always_comb begin
    idex_d = idex_q;
    vld_d  = vld_q;
    if (flush) begin
      vld_d      = 1'b0;
      idex_d.sel = '0;
    end else if (adv) begin
      vld_d = in_valid & !hazard;
      if (in_valid & in_ready) idex_d = dec;
      else idex_d.sel = '0;
    end
  end
  // ID/EX pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      idex_q <= idex_d;
      vld_q  <= vld_d;
    end
  end
  // register file write port; R0 is never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREGS; k++) regs_q[k] <= '0;
    end else if (WE && RDwb != '0) begin
      regs_q[RDwb] <= WBd;
    end
  end
  assign out_valid = vld_q;
  assign OPA       = idex_q.opa;
  assign OPB       = idex_q.opb;
  assign STR_DATA  = idex_q.str;
  assign RKo       = idex_q.rk;
  assign PCo       = idex_q.pc;
  assign RDo       = idex_q.rd;
  assign FUNTYPE   = idex_q.ft;
  assign FUNCODE   = idex_q.fc;
  assign {selWB, selMEMRD, selMEMWR, selCACHEWR, selCACHESH, selBRANCH} = idex_q.sel;
endmodule
